wbs_uart_tx: RTL and testbench
==============================

WBS_UART_TX -- requirements
Module: wbs_uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: Wishbone data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: Wishbone address width.
REQ-003 SHALL have parameter CLK_DIV, default 868: clock cycles per UART bit, legal range 2 or more.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8: TX FIFO entries, power of two.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port wb_cyc_i, input, 1 bit: Wishbone cycle.
REQ-008 SHALL have port wb_stb_i, input, 1 bit: Wishbone strobe.
REQ-009 SHALL have port wb_we_i, input, 1 bit: write enable.
REQ-010 SHALL have port wb_adr_i, input, ADDR_WIDTH bits: byte address; only bits [3:2] decoded.
REQ-011 SHALL have port wb_dat_i, input, DATA_WIDTH bits: write data.
REQ-012 SHALL have port wb_dat_o, output, DATA_WIDTH bits: read data.
REQ-013 SHALL have port wb_ack_o, output, 1 bit: acknowledge.
REQ-014 SHALL have port uart_tx, output, 1 bit: serial line, idle high.

Function
REQ-015 SHALL assert wb_ack_o exactly one cycle, in the cycle after wb_cyc_i&wb_stb_i is sampled high while wb_ack_o is low; no ack when wb_ack_o is already high (no back-to-back double ack).
REQ-016 SHALL decode adr[3:2]: 0 = TXDATA (write-only), 1 = STATUS (read; write only clears flags), 2/3 = reserved (read 0, writes ignored, still acked).
REQ-017 SHALL push wb_dat_i[7:0] into the FIFO on an acked TXDATA write when not full; when full, SHALL drop the byte, still ack, and set sticky OVF.
REQ-018 SHALL return STATUS = {count in [15:8], 4'b0, OVF [3], busy [2], empty [1], full [0]} zero-extended; busy = FSM not IDLE.
REQ-019 SHALL clear OVF on an acked STATUS write with wb_dat_i[3]=1; an overflow in the same cycle SHALL take priority (OVF stays 1).
REQ-020 SHALL drive wb_dat_o with registered read data in the ack cycle and zero otherwise; TXDATA reads return 0.
REQ-021 SHALL run FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; each bit state lasts exactly CLK_DIV cycles, timed by a baud counter that restarts on every state entry.
REQ-022 SHALL leave IDLE in the cycle after the FIFO becomes non-empty, popping one byte into the shift register at that transition.
REQ-023 SHALL send start bit 0, then 8 data bits LSB first, then stop bit 1.
REQ-024 SHALL go STOP -> START directly (no idle cycle) when the FIFO is non-empty at stop-bit end.
REQ-025 SHALL allow a push and a pop in the same cycle, including when full; count is unchanged and no overflow occurs.

Reset
REQ-026 SHALL, on rst asserted (asynchronous, mid-frame included), force uart_tx=1, wb_ack_o=0, wb_dat_o=0, FSM=IDLE, FIFO empty, OVF=0, baud counter=0.
REQ-027 SHALL resume normal operation on the first clk edge after rst deasserts.

Configuration
REQ-028 SHALL, when macro WBS_UART_TX_PARITY_EN is defined, insert state PARITY sending an even-parity bit (XOR of the 8 data bits) between DATA and STOP, giving an 11-bit frame.
REQ-029 SHALL, without WBS_UART_TX_PARITY_EN, omit the PARITY state entirely, giving a 10-bit frame.

Structure
REQ-030 SHALL place register offsets, STATUS bit positions and FSM state encodings in shared package osiris_uart_pkg, also used by uart_wbs_bridge.
REQ-031 SHALL implement the FIFO as sub-module sync_fifo (DEPTH, WIDTH=8, push/pop/full/empty/count).

Verification (CLK_DIV=4, FIFO_DEPTH=8)
REQ-032 SHALL check: after reset, STATUS read -> 0x00000002, uart_tx=1.
REQ-033 SHALL check: write 0x55 to TXDATA -> uart_tx low for cycles 0-3, then 1,0,1,0,1,0,1,0 for 4 cycles each, then high; no parity, 40 cycles total.
REQ-034 SHALL check: 10 writes with no waits -> 1 popped, 8 queued, 1 dropped; STATUS bit3=1 and full=1; write 0x8 to STATUS -> OVF=0.
REQ-035 SHALL check: writes 0xA5 then 0x3C -> second start bit begins the cycle after the first stop bit ends.
REQ-036 SHALL check: rst asserted during data bit 3 -> uart_tx=1 immediately, STATUS=0x00000002 after release.
REQ-037 SHALL check: with WBS_UART_TX_PARITY_EN, 0x07 -> parity bit 1; 0x03 -> parity bit 0; frame length 44 cycles.

Source files
------------

// File: rtl/osiris_uart_pkg.sv
// -----------------------------------------------------------------------------
// osiris_uart_pkg
// Shared definitions for the Osiris UART transmitter and its Wishbone bridge:
// register offsets (word index taken from adr[3:2]), STATUS bit positions,
// transmitter FSM state encodings and a helper that packs the STATUS word.
// Optional feature macro: WBS_UART_TX_PARITY_EN (the PARITY encoding is always
// reserved here so every user of the package agrees on the state values).
// No ports (package).
// -----------------------------------------------------------------------------
package osiris_uart_pkg;

   // Register word offsets, decoded from adr[3:2]
   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;

   // STATUS bit positions
   localparam int STAT_FULL    = 0;
   localparam int STAT_EMPTY   = 1;
   localparam int STAT_BUSY    = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 8;

   // Transmitter FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // Pack the STATUS word: {count[15:8], 4'b0, ovf, busy, empty, full}
   function automatic logic [31:0] status_word(input logic [7:0] count,
                                               input logic       ovf,
                                               input logic       busy,
                                               input logic       empty,
                                               input logic       full);
      logic [31:0] w;
      w                     = '0;
      w[STAT_CNT_LSB +: 8]  = count;
      w[STAT_OVF]           = ovf;
      w[STAT_BUSY]          = busy;
      w[STAT_EMPTY]         = empty;
      w[STAT_FULL]          = full;
      return w;
   endfunction

endpackage

// File: rtl/wbs_uart_tx_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO used as the UART TX byte queue.
// A push and a pop in the same cycle are both honoured, even when full, so the
// occupancy stays unchanged in that case.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset (pointers/count only)
//   push_i  - write data_i this cycle (ignored when full unless popping too)
//   pop_i   - consume data_o this cycle (ignored when empty)
//   data_i  - write data
//   data_o  - head entry (valid while not empty)
//   full_o  - FIFO holds DEPTH entries
//   empty_o - FIFO holds no entries
//   count_o - number of entries held
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q,  count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   // A full FIFO can still accept a byte when one leaves in the same cycle
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; only the pointers define validity
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/wbs_uart_tx.sv
// -----------------------------------------------------------------------------
// wbs_uart_tx
// Wishbone slave UART transmitter. Bytes written to TXDATA are queued in a
// FIFO and serialised as 8N1 frames (start 0, 8 data bits LSB first, stop 1),
// each bit lasting CLK_DIV clock cycles. STATUS reports FIFO count, sticky
// overflow, busy, empty and full; writing STATUS with bit 3 set clears OVF.
// Optional feature macro: WBS_UART_TX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit (11-bit frame).
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   wb_cyc_i - Wishbone cycle
//   wb_stb_i - Wishbone strobe
//   wb_we_i  - Wishbone write enable
//   wb_adr_i - byte address, only [3:2] decoded
//   wb_dat_i - write data
//   wb_dat_o - read data, valid in the ack cycle, zero otherwise
//   wb_ack_o - single-cycle acknowledge
//   uart_tx  - serial output, idle high
// -----------------------------------------------------------------------------
module wbs_uart_tx
   import osiris_uart_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CLK_DIV    = 868,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [ADDR_WIDTH-1:0] wb_adr_i,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   output logic [DATA_WIDTH-1:0] wb_dat_o,
   output logic                  wb_ack_o,
   output logic                  uart_tx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

   // Bus side
   logic                  ack_q, ack_d;
   logic [DATA_WIDTH-1:0] dat_q, dat_d;
   logic                  ovf_q, ovf_d;
   logic                  req;
   logic [1:0]            reg_sel;
   logic                  wr_txdata, wr_status, rd_status;
   logic                  overflow;
   logic [DATA_WIDTH-1:0] status_rd;

   // FIFO
   logic                  fifo_full, fifo_empty, fifo_pop;
   logic [7:0]            fifo_rd;
   logic [CW-1:0]         fifo_count;

   // Transmitter
   tx_state_e             state_q;
   logic [BW-1:0]         baud_q;
   logic [2:0]            bit_q;
   logic [7:0]            shift_q;
   logic                  tx_q;
   logic                  bit_end;
`ifdef WBS_UART_TX_PARITY_EN
   logic                  par_q;
`endif

   // Address bits outside [3:2] and the upper data byte lanes are don't-care
   logic unused_bits;
   assign unused_bits = ^{wb_adr_i[ADDR_WIDTH-1:4], wb_adr_i[1:0],
                          wb_dat_i[DATA_WIDTH-1:8]};

   // A request is accepted only while no ack is outstanding, so a held
   // strobe never produces two acks in a row.
   assign req       = wb_cyc_i & wb_stb_i & ~ack_q;
   assign reg_sel   = wb_adr_i[3:2];
   assign wr_txdata = req &  wb_we_i & (reg_sel == REG_TXDATA);
   assign wr_status = req &  wb_we_i & (reg_sel == REG_STATUS);
   assign rd_status = req & ~wb_we_i & (reg_sel == REG_STATUS);

   // A write into a full FIFO is only lost if nothing leaves in that cycle
   assign overflow  = wr_txdata & fifo_full & ~fifo_pop;

   assign status_rd = DATA_WIDTH'(status_word(8'(fifo_count), ovf_q,
                                              (state_q != ST_IDLE),
                                              fifo_empty, fifo_full));

   always_comb begin
      ack_d = req;
      dat_d = rd_status ? status_rd : '0;
      ovf_d = ovf_q;
      if (wr_status && wb_dat_i[STAT_OVF]) ovf_d = 1'b0;
      // Overflow wins over a simultaneous clear
      if (overflow) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q <= 1'b0;
         dat_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
         dat_q <= dat_d;
         ovf_q <= ovf_d;
      end
   end

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (wr_txdata),
      .pop_i   (fifo_pop),
      .data_i  (wb_dat_i[7:0]),
      .data_o  (fifo_rd),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign bit_end  = (baud_q == BAUD_LAST);
   // Bytes leave the FIFO when a frame starts: from IDLE, or straight out of
   // the stop bit for back-to-back frames.
   assign fifo_pop = ~fifo_empty &
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));

   // Transmitter FSM; tx_q is updated on every state/bit transition so the
   // line changes exactly when the baud counter restarts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
`ifdef WBS_UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         if (state_q != ST_IDLE) baud_q <= bit_end ? '0 : baud_q + 1'b1;
         case (state_q)
            ST_IDLE: begin
               baud_q <= '0;
               if (!fifo_empty) begin
                  state_q <= ST_START;
                  shift_q <= fifo_rd;
                  tx_q    <= 1'b0;
`ifdef WBS_UART_TX_PARITY_EN
                  par_q   <= ^fifo_rd;
`endif
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state_q <= ST_DATA;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (bit_q == 3'd7) begin
`ifdef WBS_UART_TX_PARITY_EN
                     state_q <= ST_PARITY;
                     tx_q    <= par_q;
`else
                     state_q <= ST_STOP;
                     tx_q    <= 1'b1;
`endif
                  end else begin
                     bit_q   <= bit_q + 1'b1;
                     shift_q <= {1'b0, shift_q[7:1]};
                     tx_q    <= shift_q[1];
                  end
               end
            end
`ifdef WBS_UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_end) begin
                  state_q <= ST_STOP;
                  tx_q    <= 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (bit_end) begin
                  if (!fifo_empty) begin
                     state_q <= ST_START;
                     shift_q <= fifo_rd;
                     tx_q    <= 1'b0;
`ifdef WBS_UART_TX_PARITY_EN
                     par_q   <= ^fifo_rd;
`endif
                  end else begin
                     state_q <= ST_IDLE;
                     tx_q    <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;
   assign uart_tx  = tx_q;

endmodule

// File: tb/tb_wbs_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_wbs_uart_tx
// Directed plus randomized bench for wbs_uart_tx (CLK_DIV=4, FIFO_DEPTH=8).
// Expected serial frames are built from the byte value alone: start 0, data
// LSB first, optional even parity, stop 1, each bit CLK_DIV cycles long.
// Optional feature macro: WBS_UART_TX_PARITY_EN (must match the RTL build).
// -----------------------------------------------------------------------------
module tb_wbs_uart_tx;

   localparam int DW      = 32;
   localparam int AW      = 32;
   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 8;
`ifdef WBS_UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic          clk;
   logic          rst;
   logic          wb_cyc_i, wb_stb_i, wb_we_i;
   logic [AW-1:0] wb_adr_i;
   logic [DW-1:0] wb_dat_i;
   logic [DW-1:0] wb_dat_o;
   logic          wb_ack_o;
   logic          uart_tx;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q[$];

   wbs_uart_tx #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_we_i  (wb_we_i),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_ack_o (wb_ack_o),
      .uart_tx  (uart_tx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected line level for bit k of the frame carrying byte b
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (FRAME_BITS == 11 && k == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic wait_ack(input string tag);
      int found;
      found = 99;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (wb_ack_o === 1'b1) begin
            found = i;
            break;
         end
      end
      check({tag, "_ack_latency"}, found, 0);
   endtask

   task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat);
      @(posedge clk); #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = {28'd0, adr}; wb_dat_i = dat;
      wait_ack("wr");
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   // Strobe is held one extra cycle to confirm the ack does not repeat and
   // read data returns to zero outside the ack cycle.
   task automatic wb_read(input logic [3:0] adr, output logic [31:0] dat);
      @(posedge clk); #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
      wb_adr_i = {28'd0, adr}; wb_dat_i = '0;
      wait_ack("rd");
      dat = wb_dat_o;
      @(posedge clk); #1;
      check("no_double_ack", {31'd0, wb_ack_o}, 32'd0);
      check("dat_zero_after_ack", wb_dat_o, 32'd0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
   endtask

   // Wait for a start bit, then check every cycle of every queued frame
   // back to back, followed by an idle-high cycle.
   task automatic check_frames(output int waited);
      int   w;
      bit   first;
      logic [7:0] b;
      w = 0;
      while (w < 64) begin
         @(posedge clk); #1;
         w++;
         if (uart_tx === 1'b0) break;
      end
      waited = w;
      check("start_found", {31'd0, uart_tx}, 32'd0);
      first = 1'b1;
      while (exp_q.size() > 0) begin
         b = exp_q.pop_front();
         for (int k = 0; k < FRAME_BITS; k++) begin
            for (int c = 0; c < CLK_DIV; c++) begin
               if (!first) begin
                  @(posedge clk); #1;
               end
               first = 1'b0;
               check($sformatf("frame_%02h_bit%0d_cyc%0d", b, k, c),
                     {31'd0, uart_tx}, {31'd0, frame_bit(b, k)});
            end
         end
      end
      @(posedge clk); #1;
      check("idle_after_frame", {31'd0, uart_tx}, 32'd1);
   endtask

   task automatic send_one(input logic [7:0] b);
      int w;
      exp_q.push_back(b);
      wb_write(4'h0, {24'd0, b});
      check_frames(w);
      check("start_latency", w, 1);
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  rb;
      int          w;

      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      wb_adr_i = '0;   wb_dat_i = '0;
      rst = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
      check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
      check("rst_dat", wb_dat_o, 32'd0);
      rst = 1'b0;
      wb_read(4'h4, rd);
      check("status_after_reset", rd, 32'h0000_0002);
      check("idle_uart_tx", {31'd0, uart_tx}, 32'd1);

      // Reserved and write-only registers
      wb_read(4'h8, rd);
      check("reserved2_read", rd, 32'd0);
      wb_read(4'h0, rd);
      check("txdata_read", rd, 32'd0);
      wb_write(4'hC, 32'hFFFF_FFFF);
      wb_read(4'h4, rd);
      check("reserved_write_ignored", rd, 32'h0000_0002);

      // Directed frames, including the parity examples
      send_one(8'h55);
      send_one(8'h07);
      send_one(8'h03);

      // Random frames
      for (int i = 0; i < 5; i++) begin
         rb = 8'($urandom_range(0, 255));
         send_one(rb);
         repeat ($urandom_range(0, 5)) @(posedge clk);
      end

      // Back-to-back frames: second start follows first stop immediately
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      fork
         begin
            wb_write(4'h0, 32'h0000_00A5);
            wb_write(4'h0, 32'h0000_003C);
         end
         check_frames(w);
      join

      // Overflow: first byte starts at once, eight are queued, one dropped
      for (int i = 0; i < 10; i++) wb_write(4'h0, 32'($urandom_range(0, 255)));
      wb_read(4'h4, rd);
      check("status_full_ovf", rd, (32'(DEPTH) << 8) | 32'h8 | 32'h4 | 32'h1);
      wb_write(4'h4, 32'h0);
      wb_read(4'h4, rd);
      check("ovf_kept_without_bit3", rd[3:0], 32'hD);
      wb_write(4'h4, 32'h8);
      wb_read(4'h4, rd);
      check("ovf_cleared", rd, (32'(DEPTH) << 8) | 32'h4 | 32'h1);

      // Drain the queue
      for (int i = 0; i < 1000; i++) begin
         wb_read(4'h4, rd);
         if (rd == 32'h2) break;
      end
      check("drained_status", rd, 32'h0000_0002);

      // Asynchronous reset in the middle of data bit 3
      rb = 8'($urandom_range(0, 255)) | 8'h08;
      wb_write(4'h0, {24'd0, rb});
      w = 0;
      while (w < 64) begin
         @(posedge clk); #1;
         w++;
         if (uart_tx === 1'b0) break;
      end
      check("rst_test_start", {31'd0, uart_tx}, 32'd0);
      repeat (CLK_DIV + 3 * CLK_DIV + 1) @(posedge clk);
      #1;
      check("in_data_bit3", {31'd0, uart_tx}, {31'd0, rb[3]});
      #2 rst = 1'b1;
      #1;
      check("async_rst_tx_high", {31'd0, uart_tx}, 32'd1);
      check("async_rst_ack", {31'd0, wb_ack_o}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      wb_read(4'h4, rd);
      check("status_after_midframe_rst", rd, 32'h0000_0002);
      repeat (2 * CLK_DIV) @(posedge clk);
      #1;
      check("idle_after_midframe_rst", {31'd0, uart_tx}, 32'd1);

      // Normal operation resumes
      send_one(8'($urandom_range(0, 255)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
